// File: rtl/mem_load_store_unit_if.sv
// rtl/mem_load_store_unit_if.sv - request, memory bus and writeback signals of the load/store unit
interface mem_load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    // master: the load/store unit itself; slave: EX stage, memory and writeback around it
    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd,
        input  mem_ack, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output wb_valid, wb_rd, wb_data, err
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd,
        output mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  wb_valid, wb_rd, wb_data, err
    );
endinterface

// File: rtl/mem_load_store_unit.sv
// rtl/mem_load_store_unit.sv - multi-cycle load/store engine between EX and a handshaked data memory
module mem_load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input logic                   clk,
    input logic                   rst_n,
    mem_load_store_unit_if.master bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          wb_valid_q, wb_valid_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    size_q, size_d;
    logic          sgn_q, sgn_d;
    logic [1:0]    off_q, off_d;

    logic          misaligned;
    logic [3:0]    acc_be;
    logic [31:0]   acc_wdata;
    logic [31:0]   shifted;
    logic [31:0]   load_data;

    always_comb begin
        misaligned = (bus.req_size == 2'b11)
                   || ((bus.req_size == 2'b01) && bus.req_addr[0])
                   || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        unique case (bus.req_size)
            2'b00: begin
                acc_be    = 4'b0001 << bus.req_addr[1:0];
                acc_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                acc_be    = 4'b0011 << bus.req_addr[1:0];
                acc_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                acc_be    = 4'b1111;
                acc_wdata = bus.req_wdata;
            end
        endcase
    end

    // Load alignment: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted = bus.mem_rdata >> {off_q, 3'b000};
        unique case (size_q)
            2'b00:   load_data = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        off_d       = off_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    size_d      = bus.req_size;
                    sgn_d       = bus.req_signed;
                    off_d       = bus.req_addr[1:0];
                    wb_rd_d     = bus.req_rd;
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
                    if (misaligned) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_we;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_be_d    = acc_be;
                        mem_wdata_d = acc_wdata;
                    end
                end
            end
            S_ACCESS: begin
                // An ack in the cycle the timeout would fire takes priority.
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d     = S_IDLE;
                        req_ready_d = 1'b1;
                    end else begin
                        state_d    = S_DONE;
                        wb_valid_d = 1'b1;
                        wb_data_d  = load_data;
                    end
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    mem_req_d   = 1'b0;
                    err_d       = 1'b1;
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            off_q       <= off_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_load_store_unit.sv
// tb/tb_mem_load_store_unit.sv - directed bench with a cycle-level expectation model for mem_load_store_unit
module tb_mem_load_store_unit;
    localparam int TO = 4;

    logic clk;
    logic rst_n;
    mem_load_store_unit_if bus();

    mem_load_store_unit #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit armed = 1'b0;

    logic        exp_ready, exp_mem_req, exp_we, exp_wb_valid, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_wbdata;
    logic [3:0]  exp_be;
    logic [4:0]  exp_rd;

    int          n_wb, n_err, n_req;
    logic [3:0]  last_be;
    logic [31:0] last_wdata, last_wbdata;
    logic        last_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Specification rules expressed with plain arithmetic on byte counts
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_bad(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int v;
        v = ((1 << nbytes(size)) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = nbytes(size);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [1:0] size,
                                           input logic sgn, input logic [31:0] addr);
        longint v, span;
        span = longint'(1) << (8 * nbytes(size));
        v = longint'(rdata >> (8 * (addr % 4))) % span;
        if (sgn && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            chk("req_ready", bus.req_ready, exp_ready);
            chk("mem_req", bus.mem_req, exp_mem_req);
            chk("wb_valid", bus.wb_valid, exp_wb_valid);
            chk("err", bus.err, exp_err);
            if (exp_mem_req) begin
                chk("mem_we", bus.mem_we, exp_we);
                chk("mem_addr", bus.mem_addr, exp_addr);
                chk("mem_be", bus.mem_be, exp_be);
                if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
            end
            if (exp_wb_valid) begin
                chk("wb_rd", bus.wb_rd, exp_rd);
                chk("wb_data", bus.wb_data, exp_wbdata);
            end
            if (bus.wb_valid) begin n_wb++; last_wbdata = bus.wb_data; end
            if (bus.err) n_err++;
            if (bus.mem_req) begin
                n_req++;
                last_be = bus.mem_be;
                last_wdata = bus.mem_wdata;
                last_we = bus.mem_we;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        exp_ready = 1'b1; exp_mem_req = 1'b0; exp_wb_valid = 1'b0; exp_err = 1'b0;
    endtask

    task automatic clr_obs();
        n_wb = 0; n_err = 0; n_req = 0;
    endtask

    task automatic start_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_rd = rd;
        set_idle();
        step();
        bus.req_valid = 1'b0;
        bus.req_we = ~we; bus.req_size = $urandom_range(0, 3); bus.req_signed = ~sgn;
        bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_rd = 5'($urandom);
        exp_ready = 1'b0;
        exp_we = we; exp_addr = {addr[31:2], 2'b00}; exp_be = m_be(size, addr);
        exp_wdata = m_wdata(size, wdata); exp_rd = rd;
    endtask

    // ack_at: ACCESS cycle (1-based) carrying mem_ack; 0 means never acknowledge
    task automatic access(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input int ack_at, input logic [31:0] rdata);
        start_req(we, size, sgn, addr, wdata, rd);
        if (m_bad(size, addr)) begin
            exp_err = 1'b1;
            step();
            set_idle();
            return;
        end
        exp_mem_req = 1'b1;
        for (int k = 1; k <= TO; k++) begin
            bus.mem_ack = (k == ack_at);
            bus.mem_rdata = (k == ack_at) ? rdata : $urandom;
            step();
            bus.mem_ack = 1'b0;
            if (k == ack_at) begin
                exp_mem_req = 1'b0;
                if (we) begin
                    set_idle();
                end else begin
                    exp_wb_valid = 1'b1;
                    exp_wbdata = m_load(rdata, size, sgn, addr);
                    step();
                    set_idle();
                end
                return;
            end
        end
        set_idle();
        exp_err = 1'b1;
        step();
        exp_err = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        set_idle();
        clr_obs();
        #1 rst_n = 1'b0;
        step();
        armed = 1'b1;
        chk("rst mem_addr", bus.mem_addr, 32'h0);
        chk("rst mem_be", bus.mem_be, 32'h0);
        chk("rst mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst wb_data", bus.wb_data, 32'h0);
        chk("rst wb_rd", bus.wb_rd, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // 1 word load, ack on the 3rd ACCESS cycle
        clr_obs();
        access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd5, 3, 32'hDEADBEEF);
        chk("t1 be", last_be, 32'hF);
        chk("t1 wb_data", last_wbdata, 32'hDEADBEEF);
        chk("t1 wb pulses", n_wb, 1);
        chk("t1 req cycles", n_req, 3);

        // 2 byte loads from the top lane
        access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd7, 1, 32'h80112233);
        chk("t2s wb_data", last_wbdata, 32'hFFFFFF80);
        chk("t2 be", last_be, 32'h8);
        access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7, 2, 32'h80112233);
        chk("t2u wb_data", last_wbdata, 32'h00000080);

        // 3 half store at the upper half
        clr_obs();
        access(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 5'd0, 2, 32'h0);
        chk("t3 be", last_be, 32'hC);
        chk("t3 wdata", last_wdata, 32'hABCDABCD);
        chk("t3 we", last_we, 1);
        chk("t3 no wb", n_wb, 0);

        // 4 misaligned word and other illegal requests
        clr_obs();
        access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd1, 1, 32'h0);
        chk("t4 err pulses", n_err, 1);
        chk("t4 req cycles", n_req, 0);
        access(1'b1, 2'd3, 1'b0, 32'h100, 32'h0, 5'd1, 1, 32'h0);
        access(1'b0, 2'd1, 1'b1, 32'h201, 32'h0, 5'd1, 1, 32'h0);

        // further lane and extension patterns, rd=0 still produces wb_valid
        access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 5'd0, 1, 32'h80011234);
        chk("half sext", last_wbdata, 32'hFFFF8001);
        access(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 5'd31, 3, 32'h80112233);
        chk("byte lane1", last_wbdata, 32'h00000022);
        access(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 5'd9, 1, 32'h1234F00D);
        access(1'b1, 2'd0, 1'b0, 32'h301, 32'h1234565A, 5'd0, 1, 32'h0);
        chk("byte store wdata", last_wdata, 32'h5A5A5A5A);
        access(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D, 5'd0, 4, 32'h0);

        // mem_ack outside ACCESS is ignored
        bus.mem_ack = 1'b1;
        step();
        step();
        bus.mem_ack = 1'b0;

        // 5 timeout, then ack on the cycle the timeout would fire
        clr_obs();
        access(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 5'd3, 0, 32'h0);
        chk("t5 req cycles", n_req, TO);
        chk("t5 err pulses", n_err, 1);
        chk("t5 no wb", n_wb, 0);
        clr_obs();
        access(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 5'd3, TO, 32'h13572468);
        chk("t5b err pulses", n_err, 0);
        chk("t5b wb pulses", n_wb, 1);
        chk("t5b wb_data", last_wbdata, 32'h13572468);

        // 6 reset mid-ACCESS
        start_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd2);
        exp_mem_req = 1'b1;
        step();
        #2 rst_n = 1'b0;
        set_idle();
        #1;
        chk("t6 mem_req", bus.mem_req, 0);
        chk("t6 req_ready", bus.req_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        step();
        clr_obs();
        access(1'b0, 2'd0, 1'b0, 32'h402, 32'h0, 5'd4, 2, 32'hAABBCCDD);
        chk("t6 after wb", last_wbdata, 32'h000000BB);
        chk("t6 after pulses", n_wb, 1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
